bank_timing_fsm: RTL
====================

// Module: bank_timing_fsm
// PURPOSE
// - Per-bank controller FSM, parametrised successor of the original bank FSM: one instance per DRAM bank.
// - Accepts decoded read/write requests for its bank and sequences ACT / RD / WR / PRE toward the command arbiter.
// - Enforces tRCD, tRP, tRAS and tWR with internal counters instead of relying only on arbiter stall.
// - Tracks the open row; supports open-page (row hit) and auto-precharge closing.
// PARAMETERS
// - ROW_BITS   14  row address width
// - COL_BITS   14  column address width; ba_addr width = max(ROW_BITS,COL_BITS)
// - BA_BITS    3   bank index width
// - BANK_ID    0   bank served by this instance
// - T_RCD      4   min cycles from ACT issue to RD/WR issue (>=1)
// - T_RP       4   min cycles from PRE issue to next ACT issue (>=1)
// - T_RAS      10  min cycles from ACT issue to PRE issue (>=1)
// - T_WR       5   min cycles from WR issue to PRE issue (>=1)
// - CNT_W      5   timing counter width; every T_* must be < 2**CNT_W
// PORTS
// - clk           in   1   clock, all logic on rising edge
// - rst           in   1   synchronous reset, active-high
// - init_done     in   1   DRAM init sequence complete
// - cmd_valid     in   1   request valid
// - cmd_rw        in   1   1 = read, 0 = write
// - cmd_bank      in   BA_BITS   target bank
// - cmd_row       in   ROW_BITS  row address
// - cmd_col       in   COL_BITS  column address
// - cmd_auto_pre  in   1   close row after this access
// - cmd_ready     out  1   bank can accept a request this cycle
// - ba_req        out  1   command request to arbiter
// - ba_cmd        out  2   0 ACT, 1 RD, 2 WR, 3 PRE
// - ba_addr       out  max(ROW_BITS,COL_BITS)  row (ACT) or col (RD/WR), zero-extended; 0 for PRE
// - ba_ap         out  1   auto-precharge flag with RD/WR
// - grant         in   1   arbiter accepts ba_req this cycle (issue cycle)
// - ba_busy       out  1   not in IDLE/STANDBY
// - row_open      out  1   a row is open
// - open_row      out  ROW_BITS  currently open row
// BEHAVIOUR
// - Reset: state INIT; cmd_ready, ba_req, ba_ap, row_open = 0; ba_cmd, ba_addr, open_row = 0; all counters 0; ba_busy = 1.
// - Accept = cmd_valid & cmd_ready & (cmd_bank==BANK_ID); registers rw/row/col/auto_pre. cmd_ready = 1 only in IDLE or STANDBY.
// - States: INIT -> IDLE when init_done.
// - IDLE: accept -> ACT_REQ.
// - ACT_REQ: ba_req=1, ba_cmd=ACT; hold until grant; on grant load rcd_cnt=T_RCD-1, ras_cnt=T_RAS-1, set row_open, open_row <= row, -> RCD_WAIT.
// - RCD_WAIT: ba_req=0 until rcd_cnt==0, then -> RW_REQ (T_RCD==1 goes direct).
// - RW_REQ: ba_req=1, ba_cmd=RD/WR, ba_ap=auto_pre; on grant: WR loads wr_cnt=T_WR-1; auto_pre=1 -> PRE_WAIT, else -> STANDBY.
// - STANDBY: accept with row==open_row -> RW_REQ same cycle transition (hit, no ACT); miss -> PRE_WAIT.
// - PRE_WAIT: wait until ras_cnt==0 and wr_cnt==0, then -> PRE_REQ (or, when auto_pre, straight to closing: clear row_open, load rp_cnt=T_RP-1, -> RP_WAIT; no PRE command sent).
// - PRE_REQ: ba_req=1, ba_cmd=PRE, ba_addr=0; on grant clear row_open, load rp_cnt=T_RP-1, -> RP_WAIT.
// - RP_WAIT: at rp_cnt==0 -> ACT_REQ if a miss request is pending, else IDLE.
// - Counters decrement every cycle while nonzero, saturate at 0, run concurrently regardless of state.
// - ba_req, once raised, stays high with stable ba_cmd/ba_addr until grant; grant without ba_req is ignored.
// - Requests for other banks never change state. rst in any state returns to reset values next cycle; in-flight request dropped.
// CONFIGURATION
// - PAGE_TIMEOUT_EN defined: adds parameter IDLE_TIMEOUT (default 16); STANDBY with no accept for IDLE_TIMEOUT consecutive
//   cycles -> PRE_WAIT with no pending request, closing the row; counter clears on any accept.
// - PAGE_TIMEOUT_EN undefined: row stays open in STANDBY indefinitely; no timeout logic synthesised.
// TESTING
// - Reset, init_done=1 -> IDLE next cycle, cmd_ready=1, ba_req=0, row_open=0.
// - Read row 5 col 8, grant always 1 -> ACT issue cycle N, RD issue at N+4, STANDBY, open_row=5.
// - Row hit: read row 5 col 9 from STANDBY -> RD issued without ACT, 1 cycle after accept.
// - Row miss row 7 right after ACT at N -> PRE not before N+10; ACT(row 7) not before PRE+4.
// - Write with auto_pre, grant held low 3 cycles -> ba_req/ba_cmd stable; row closes >= WR+5; return to IDLE.
// - Request with cmd_bank != BANK_ID -> no state change; with PAGE_TIMEOUT_EN, 16 idle STANDBY cycles -> PRE issued.

Source files
------------

// File: rtl/bank_timing_fsm.sv
// Per-bank DRAM controller FSM: sequences ACT/RD/WR/PRE toward the arbiter while enforcing tRCD/tRP/tRAS/tWR.
// Optional macro PAGE_TIMEOUT_EN closes an idle open page after IDLE_TIMEOUT STANDBY cycles.
module bank_timing_fsm #(
  parameter int unsigned ROW_BITS = 14,
  parameter int unsigned COL_BITS = 14,
  parameter int unsigned BA_BITS  = 3,
  parameter int unsigned BANK_ID  = 0,
  parameter int unsigned T_RCD    = 4,
  parameter int unsigned T_RP     = 4,
  parameter int unsigned T_RAS    = 10,
  parameter int unsigned T_WR     = 5,
  parameter int unsigned CNT_W    = 5,
`ifdef PAGE_TIMEOUT_EN
  parameter int unsigned IDLE_TIMEOUT = 16,
`endif
  localparam int unsigned ADDR_W = (ROW_BITS > COL_BITS) ? ROW_BITS : COL_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                init_done,
  input  logic                cmd_valid,
  input  logic                cmd_rw,
  input  logic [BA_BITS-1:0]  cmd_bank,
  input  logic [ROW_BITS-1:0] cmd_row,
  input  logic [COL_BITS-1:0] cmd_col,
  input  logic                cmd_auto_pre,
  output logic                cmd_ready,
  output logic                ba_req,
  output logic [1:0]          ba_cmd,
  output logic [ADDR_W-1:0]   ba_addr,
  output logic                ba_ap,
  input  logic                grant,
  output logic                ba_busy,
  output logic                row_open,
  output logic [ROW_BITS-1:0] open_row
);

  localparam logic [1:0] CMD_ACT = 2'd0;
  localparam logic [1:0] CMD_RD  = 2'd1;
  localparam logic [1:0] CMD_WR  = 2'd2;
  localparam logic [1:0] CMD_PRE = 2'd3;

  localparam logic [CNT_W-1:0] RCD_LD = CNT_W'(T_RCD - 1);
  localparam logic [CNT_W-1:0] RP_LD  = CNT_W'(T_RP - 1);
  localparam logic [CNT_W-1:0] RAS_LD = CNT_W'(T_RAS - 1);
  localparam logic [CNT_W-1:0] WR_LD  = CNT_W'(T_WR - 1);

  typedef enum logic [3:0] {
    ST_INIT, ST_IDLE, ST_ACT_REQ, ST_RCD_WAIT, ST_RW_REQ,
    ST_STANDBY, ST_PRE_WAIT, ST_PRE_REQ, ST_RP_WAIT
  } state_e;

  state_e state_q, state_d;
  logic                rw_q, rw_d, ap_q, ap_d;
  logic [ROW_BITS-1:0] row_q, row_d;
  logic [COL_BITS-1:0] col_q, col_d;
  logic                pend_q, pend_d, auto_close_q, auto_close_d;
  logic [CNT_W-1:0]    rcd_q, rcd_d, rp_q, rp_d, ras_q, ras_d, wr_q, wr_d;
  logic [CNT_W-1:0]    rcd_dec, rp_dec, ras_dec, wr_dec;
  logic                cmd_ready_q, cmd_ready_d, ba_req_q, ba_req_d, ba_ap_q, ba_ap_d;
  logic                ba_busy_q, ba_busy_d, row_open_q, row_open_d;
  logic [1:0]          ba_cmd_q, ba_cmd_d;
  logic [ADDR_W-1:0]   ba_addr_q, ba_addr_d;
  logic [ROW_BITS-1:0] open_row_q, open_row_d;
  logic                accept, issue;
`ifdef PAGE_TIMEOUT_EN
  localparam int unsigned IDLE_W = $clog2(IDLE_TIMEOUT + 1);
  logic [IDLE_W-1:0]   idle_q, idle_d;
`endif

  // Next-state, counter and registered-output computation.
  always_comb begin
    accept  = cmd_valid & cmd_ready_q & (cmd_bank == BA_BITS'(BANK_ID));
    issue   = grant & ba_req_q;
    rcd_dec = (rcd_q != '0) ? rcd_q - CNT_W'(1) : '0;
    rp_dec  = (rp_q  != '0) ? rp_q  - CNT_W'(1) : '0;
    ras_dec = (ras_q != '0) ? ras_q - CNT_W'(1) : '0;
    wr_dec  = (wr_q  != '0) ? wr_q  - CNT_W'(1) : '0;

    state_d      = state_q;
    rw_d         = rw_q;
    ap_d         = ap_q;
    row_d        = row_q;
    col_d        = col_q;
    pend_d       = pend_q;
    auto_close_d = auto_close_q;
    rcd_d        = rcd_dec;
    rp_d         = rp_dec;
    ras_d        = ras_dec;
    wr_d         = wr_dec;
    row_open_d   = row_open_q;
    open_row_d   = open_row_q;
    ba_cmd_d     = ba_cmd_q;
    ba_addr_d    = ba_addr_q;
`ifdef PAGE_TIMEOUT_EN
    idle_d       = '0;
`endif

    if (accept) begin
      rw_d  = cmd_rw;
      ap_d  = cmd_auto_pre;
      row_d = cmd_row;
      col_d = cmd_col;
    end

    case (state_q)
      ST_INIT: if (init_done) state_d = ST_IDLE;
      ST_IDLE: if (accept) begin
        pend_d  = 1'b0;
        state_d = ST_ACT_REQ;
      end
      ST_ACT_REQ: if (issue) begin
        rcd_d      = RCD_LD;
        ras_d      = RAS_LD;
        row_open_d = 1'b1;
        open_row_d = row_q;
        state_d    = (RCD_LD == '0) ? ST_RW_REQ : ST_RCD_WAIT;
      end
      // Leave one cycle early so the RD/WR request is visible when tRCD expires.
      ST_RCD_WAIT: if (rcd_dec == '0) state_d = ST_RW_REQ;
      ST_RW_REQ: if (issue) begin
        if (!rw_q) wr_d = WR_LD;
        if (ap_q) begin
          auto_close_d = 1'b1;
          pend_d       = 1'b0;
          state_d      = ST_PRE_WAIT;
        end else begin
          state_d = ST_STANDBY;
        end
      end
      ST_STANDBY: begin
        if (accept) begin
          if (cmd_row == open_row_q) begin
            state_d = ST_RW_REQ;
          end else begin
            pend_d       = 1'b1;
            auto_close_d = 1'b0;
            state_d      = ST_PRE_WAIT;
          end
        end
`ifdef PAGE_TIMEOUT_EN
        else if (idle_q == IDLE_W'(IDLE_TIMEOUT - 1)) begin
          pend_d       = 1'b0;
          auto_close_d = 1'b0;
          state_d      = ST_PRE_WAIT;
        end else begin
          idle_d = idle_q + IDLE_W'(1);
        end
`endif
      end
      // Auto-precharge closes in the cycle a PRE could legally issue; no command is sent.
      ST_PRE_WAIT: begin
        if (auto_close_q) begin
          if ((ras_q == '0) && (wr_q == '0)) begin
            row_open_d   = 1'b0;
            auto_close_d = 1'b0;
            rp_d         = RP_LD;
            state_d      = (RP_LD != '0) ? ST_RP_WAIT : (pend_q ? ST_ACT_REQ : ST_IDLE);
          end
        end else if ((ras_dec == '0) && (wr_dec == '0)) begin
          state_d = ST_PRE_REQ;
        end
      end
      ST_PRE_REQ: if (issue) begin
        row_open_d = 1'b0;
        rp_d       = RP_LD;
        state_d    = (RP_LD != '0) ? ST_RP_WAIT : (pend_q ? ST_ACT_REQ : ST_IDLE);
      end
      ST_RP_WAIT: if (rp_dec == '0) state_d = pend_q ? ST_ACT_REQ : ST_IDLE;
      default: state_d = ST_INIT;
    endcase

    if ((state_q != ST_ACT_REQ) && (state_d == ST_ACT_REQ)) pend_d = 1'b0;

    cmd_ready_d = (state_d == ST_IDLE) || (state_d == ST_STANDBY);
    ba_busy_d   = !cmd_ready_d;
    ba_req_d    = (state_d == ST_ACT_REQ) || (state_d == ST_RW_REQ) || (state_d == ST_PRE_REQ);
    ba_ap_d     = (state_d == ST_RW_REQ) && ap_d;
    case (state_d)
      ST_ACT_REQ: begin
        ba_cmd_d  = CMD_ACT;
        ba_addr_d = ADDR_W'(row_d);
      end
      ST_RW_REQ: begin
        ba_cmd_d  = rw_d ? CMD_RD : CMD_WR;
        ba_addr_d = ADDR_W'(col_d);
      end
      ST_PRE_REQ: begin
        ba_cmd_d  = CMD_PRE;
        ba_addr_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_INIT;
      rw_q         <= 1'b0;
      ap_q         <= 1'b0;
      row_q        <= '0;
      col_q        <= '0;
      pend_q       <= 1'b0;
      auto_close_q <= 1'b0;
      rcd_q        <= '0;
      rp_q         <= '0;
      ras_q        <= '0;
      wr_q         <= '0;
      cmd_ready_q  <= 1'b0;
      ba_req_q     <= 1'b0;
      ba_cmd_q     <= '0;
      ba_addr_q    <= '0;
      ba_ap_q      <= 1'b0;
      ba_busy_q    <= 1'b1;
      row_open_q   <= 1'b0;
      open_row_q   <= '0;
`ifdef PAGE_TIMEOUT_EN
      idle_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      rw_q         <= rw_d;
      ap_q         <= ap_d;
      row_q        <= row_d;
      col_q        <= col_d;
      pend_q       <= pend_d;
      auto_close_q <= auto_close_d;
      rcd_q        <= rcd_d;
      rp_q         <= rp_d;
      ras_q        <= ras_d;
      wr_q         <= wr_d;
      cmd_ready_q  <= cmd_ready_d;
      ba_req_q     <= ba_req_d;
      ba_cmd_q     <= ba_cmd_d;
      ba_addr_q    <= ba_addr_d;
      ba_ap_q      <= ba_ap_d;
      ba_busy_q    <= ba_busy_d;
      row_open_q   <= row_open_d;
      open_row_q   <= open_row_d;
`ifdef PAGE_TIMEOUT_EN
      idle_q       <= idle_d;
`endif
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign ba_req    = ba_req_q;
  assign ba_cmd    = ba_cmd_q;
  assign ba_addr   = ba_addr_q;
  assign ba_ap     = ba_ap_q;
  assign ba_busy   = ba_busy_q;
  assign row_open  = row_open_q;
  assign open_row  = open_row_q;

endmodule
